kbd_responder: RTL
==================

KBD_RESPONDER -- requirements
Module: kbd_responder

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, scancode FIFO entries, power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 The port list SHALL be as follows; one clock; reset is asynchronous and active-high.
- clk  input  1  system clock, same domain as the CPU data port.
- rst  input  1  asynchronous reset, active-high.
- ps2_clk  input  1  keyboard clock, asynchronous to clk.
- ps2_data  input  1  keyboard data, asynchronous to clk.
- dmem_read_in  input  1  CPU data read request.
- dmem_addr  input  30  CPU word address.
- kbd_sel  output  1  high when dmem_addr[29:26]==4'he.
- kbd_stall  output  1  stalls the CPU for the capture cycle of a new read.
- kbd_data_out  output  32  registered read data.

Function
REQ-004 The block SHALL synchronize ps2_clk and ps2_data through two flops each and detect ps2_clk falling edges on the synchronized copy.
REQ-005 Receiver FSM states SHALL be IDLE, SHIFT, CHECK: IDLE->SHIFT on a falling edge with data 0 (start bit); SHIFT samples 8 data bits LSB first, then parity, then stop (10 edges); CHECK lasts one cycle, then returns to IDLE.
REQ-006 In CHECK a frame SHALL be accepted only if parity is odd over data+parity and stop==1; otherwise the byte is discarded and sticky frame_err is set.
REQ-007 In IDLE a falling edge with data 1 SHALL be ignored.
REQ-008 In SHIFT, TIMEOUT_CYCLES consecutive cycles without a falling edge SHALL return the FSM to IDLE, discard the partial frame, and set frame_err.
REQ-009 An accepted byte SHALL be pushed into the FIFO in the CHECK cycle; if the FIFO is full, the byte is dropped and sticky overflow is set.
REQ-010 Word offset dmem_addr[0]==0 SHALL be STATUS: [31]=nonempty, [30]=overflow, [29]=frame_err, [6:0]=count; all other bits 0.
REQ-011 Word offset dmem_addr[0]==1 SHALL be DATA: [31]=1 and [7:0]=FIFO head if nonempty, else all zero.
REQ-012 A new access SHALL be defined as dmem_read_in && kbd_sel when the previous cycle had no selected read, or had one at a different dmem_addr.
REQ-013 kbd_stall SHALL be combinational and high only in the cycle of a new access; that clock edge captures kbd_data_out.
REQ-014 The FIFO SHALL pop exactly once per new DATA access when nonempty; held reads and empty reads SHALL NOT pop.
REQ-015 A new STATUS access SHALL clear overflow and frame_err after capturing their values; an event in the same cycle SHALL win, leaving the flag set.
REQ-016 A push and a pop in the same cycle SHALL leave count unchanged; a pop of a full FIFO plus a push SHALL NOT set overflow.
REQ-017 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-018 kbd_data_out SHALL hold its value until the next new access.

Reset
REQ-019 On rst, asynchronously: FSM=IDLE, bit counter 0, timeout counter 0, FIFO empty, pointers 0, overflow=0, frame_err=0, kbd_data_out=0, sync flops=1, access-tracking register cleared.
REQ-020 Reset mid-frame SHALL discard the partial frame; after release, reception SHALL resume at the next start bit.

Structure
REQ-021 Shared package kbd_pkg SHALL hold KBD_REGION (4'he), STATUS/DATA offsets, status bit positions, and FSM state encodings.
REQ-022 The FIFO SHALL be a sub-module named kbd_fifo (push, pop, full, empty, count, head); receiver and register logic SHALL stay in kbd_responder.

Verification
REQ-023 Send frame 0x1C with odd parity, then read DATA -> kbd_stall for 1 cycle, kbd_data_out=0x8000001C, count 1->0.
REQ-024 Send 0x1C with bad parity, then read STATUS -> 0x20000000; a second STATUS read returns 0x00000000.
REQ-025 Send FIFO_DEPTH+1 frames, then read STATUS -> 0xC0000010; drain 16 DATA reads in order, with the 17th byte absent.
REQ-026 Hold dmem_read_in at DATA for 5 cycles with 2 bytes queued -> exactly one pop, stall only in cycle 1, count=1.
REQ-027 Stop ps2_clk after 4 bits for TIMEOUT_CYCLES+1 cycles, then send 0x5A -> frame_err=1, FIFO holds only 0x5A.
REQ-028 Assert rst during bit 5 of a frame -> all outputs 0, FIFO empty; the next full frame 0x29 is received correctly.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants, register map and receiver state encoding for the PS/2 keyboard responder.
package kbd_pkg;

  localparam logic [3:0] KBD_REGION = 4'he;

  // Word offsets within the keyboard region, selected by dmem_addr[0]
  localparam logic OFS_STATUS = 1'b0;
  localparam logic OFS_DATA   = 1'b1;

  // STATUS word layout
  localparam int ST_NONEMPTY  = 31;
  localparam int ST_OVERFLOW  = 30;
  localparam int ST_FRAME_ERR = 29;
  localparam int ST_COUNT_W   = 7;

  // DATA word layout
  localparam int DT_VALID = 31;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // frame[7:0]=data, frame[8]=parity, frame[9]=stop; valid when parity is odd and stop is high
  function automatic logic frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) && frame[9];
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scancode FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_responder.sv
// PS/2 keyboard receiver with scancode FIFO, exposed to the CPU as a STATUS/DATA register pair.
module kbd_responder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        dmem_read_in,
  input  logic [29:0] dmem_addr,
  output logic        kbd_sel,
  output logic        kbd_stall,
  output logic [31:0] kbd_data_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- PS/2 input synchronization ----------------
  logic [1:0] clk_sync, data_sync;
  logic       clk_last;
  logic       ps2_fall, bit_in;

  // Two-flop synchronizers plus a history flop for falling-edge detection; idle-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_last  <= clk_sync[1];
    end
  end

  assign ps2_fall = clk_last && !clk_sync[1];
  assign bit_in   = data_sync[1];

  // ---------------- Receiver FSM ----------------
  rx_state_t     state, state_nxt;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [9:0]    frame;
  logic          rx_push, rx_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  // Next state; CHECK produces either a push or a frame error, timeout abandons a partial frame
  always_comb begin
    state_nxt = state;
    rx_push   = 1'b0;
    rx_err    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (ps2_fall && !bit_in) state_nxt = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (ps2_fall) begin
          if (bit_cnt == 4'd9) state_nxt = RX_CHECK;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = RX_IDLE;
          rx_err    = 1'b1;
        end
      end
      RX_CHECK: begin
        state_nxt = RX_IDLE;
        if (frame_ok(frame)) rx_push = 1'b1;
        else                 rx_err  = 1'b1;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Shift register (LSB first into the top), bit counter and inactivity counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
      frame   <= '0;
    end else begin
      if (state != RX_SHIFT) begin
        bit_cnt <= '0;
      end else if (ps2_fall) begin
        bit_cnt <= bit_cnt + 1'b1;
        frame   <= {bit_in, frame[9:1]};
      end
      if (state != RX_SHIFT || ps2_fall) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---------------- CPU access decode ----------------
  logic        sel_rd, new_acc, is_data;
  logic        prev_vld;
  logic [29:0] prev_addr;

  assign kbd_sel   = (dmem_addr[29:26] == KBD_REGION);
  assign sel_rd    = dmem_read_in && kbd_sel;
  assign new_acc   = sel_rd && (!prev_vld || (prev_addr != dmem_addr));
  assign is_data   = (dmem_addr[0] == OFS_DATA);
  assign kbd_stall = new_acc;

  // Remember last cycle's selected read so a held read is only serviced once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_vld  <= 1'b0;
      prev_addr <= '0;
    end else begin
      prev_vld  <= sel_rd;
      prev_addr <= dmem_addr;
    end
  end

  // ---------------- FIFO ----------------
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;

  assign fifo_pop = new_acc && is_data;

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .din   (frame[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // ---------------- Sticky flags and read data ----------------
  logic        overflow, frame_err, ovf_evt;
  logic [31:0] status_word, data_word;

  // A full FIFO that is popped this cycle still accepts the push
  assign ovf_evt = rx_push && fifo_full && !(fifo_pop && !fifo_empty);

  // Register images as seen before this cycle's updates
  always_comb begin
    status_word                           = '0;
    status_word[ST_NONEMPTY]              = !fifo_empty;
    status_word[ST_OVERFLOW]              = overflow;
    status_word[ST_FRAME_ERR]             = frame_err;
    status_word[ST_COUNT_W-1:0]           = ST_COUNT_W'(fifo_count);
    data_word                             = '0;
    if (!fifo_empty) begin
      data_word[DT_VALID] = 1'b1;
      data_word[7:0]      = fifo_head;
    end
  end

  // Sticky flags: a STATUS read clears them unless a new event lands in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (new_acc && !is_data) begin
      overflow  <= ovf_evt;
      frame_err <= rx_err;
    end else begin
      overflow  <= overflow || ovf_evt;
      frame_err <= frame_err || rx_err;
    end
  end

  // Read data captured only on a new access and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          kbd_data_out <= '0;
    else if (new_acc) kbd_data_out <= is_data ? data_word : status_word;
  end

endmodule
